// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock chamber arbiter.
package airlock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ACK,
        RUN,
        RELEASE,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_ARR  = 2'b01,
        GRANT_DEP  = 2'b10
    } grant_t;

    localparam int ACK_WAIT_DEFAULT = 4;

endpackage

// File: rtl/airlock_if.sv
// Handshake bundle between the airlock arbiter, the two workflow FSMs and the pump driver.
interface airlock_if;

    logic       arr_req;
    logic       dep_req;
    logic       arr_busy;
    logic       dep_busy;
    logic       arr_press;
    logic       arr_depress;
    logic       dep_press;
    logic       dep_depress;
    logic       arr_start;
    logic       dep_start;
    logic       pump_up;
    logic       pump_down;
    logic [1:0] grant;
    logic       fault;

    modport master (
        output arr_req, dep_req, arr_busy, dep_busy,
        output arr_press, arr_depress, dep_press, dep_depress,
        input  arr_start, dep_start, pump_up, pump_down, grant, fault
    );

    modport slave (
        input  arr_req, dep_req, arr_busy, dep_busy,
        input  arr_press, arr_depress, dep_press, dep_depress,
        output arr_start, dep_start, pump_up, pump_down, grant, fault
    );

endinterface

// File: rtl/airlock_watchdog.sv
// RUN-duration counter for the airlock arbiter; only built when AIRLOCK_WATCHDOG_EN is defined.
module airlock_watchdog #(
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic run_enter,
    input  logic run_active,
    output logic timeout
);

    localparam int CNT_W = $clog2(WATCHDOG_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WATCHDOG_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (run_enter) begin
            count_q <= '0;
        end else if (run_active && !timeout) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign timeout = run_active && (count_q == LAST);

endmodule

// File: rtl/airlock_arbiter.sv
// Grants the shared airlock chamber and pump to the arrival or departure workflow with
// alternating priority. Optional stuck-RUN watchdog enabled by macro AIRLOCK_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | no grant; choose among pending requests
// START   | one-cycle start pulse to the selected side
// ACK     | wait up to ACK_WAIT cycles for the selected side's busy
// RUN     | granted side drives the pump through registered outputs
// RELEASE | one dead cycle, pump off, before the next grant
// FAULT   | pump off, fault raised; held until reset
module airlock_arbiter
    import airlock_pkg::*;
#(
    parameter int ACK_WAIT        = ACK_WAIT_DEFAULT,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic     clock,
    input  logic     reset,
    airlock_if.slave bus
);

    localparam int ACK_W = $clog2(ACK_WAIT + 1);
    localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_WAIT - 1);

    if (ACK_WAIT < 1 || WATCHDOG_CYCLES < 2) begin : g_param_check
        $error("airlock_arbiter: ACK_WAIT must be >= 1 and WATCHDOG_CYCLES >= 2");
    end

    state_t           state_q, state_d;
    grant_t           sel_q, sel_d, last_q;
    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             pend_arr_q, pend_arr_d;
    logic             pend_dep_q, pend_dep_d;
    logic             pump_up_q, pump_down_q;
    logic             granting, busy, press, depress;
    logic             run_hold, wd_timeout;

    assign granting = (state_q == START) || (state_q == ACK) || (state_q == RUN);
    assign busy     = (sel_q == GRANT_ARR) ? bus.arr_busy    : bus.dep_busy;
    assign press    = (sel_q == GRANT_ARR) ? bus.arr_press   : bus.dep_press;
    assign depress  = (sel_q == GRANT_ARR) ? bus.arr_depress : bus.dep_depress;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ack_cnt_d = ack_cnt_q;
        case (state_q)
            IDLE: begin
                if (pend_arr_q && pend_dep_q) begin
                    sel_d   = (last_q == GRANT_ARR) ? GRANT_DEP : GRANT_ARR;
                    state_d = START;
                end else if (pend_arr_q) begin
                    sel_d   = GRANT_ARR;
                    state_d = START;
                end else if (pend_dep_q) begin
                    sel_d   = GRANT_DEP;
                    state_d = START;
                end
            end
            START: begin
                ack_cnt_d = ACK_LOAD;
                state_d   = ACK;
            end
            ACK: begin
                if (busy) begin
                    state_d = RUN;
                end else if (ack_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q - ACK_W'(1);
                end
            end
            RUN: begin
                if ((press && depress) || wd_timeout) begin
                    state_d = FAULT;
                end else if (!busy) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // A request from the side holding the chamber is dropped, never queued behind itself.
    always_comb begin
        pend_arr_d = pend_arr_q;
        pend_dep_d = pend_dep_q;
        if (state_q == START && sel_q == GRANT_ARR) pend_arr_d = 1'b0;
        if (state_q == START && sel_q == GRANT_DEP) pend_dep_d = 1'b0;
        if (bus.arr_req && !(granting && sel_q == GRANT_ARR)) pend_arr_d = 1'b1;
        if (bus.dep_req && !(granting && sel_q == GRANT_DEP)) pend_dep_d = 1'b1;
    end

    // Pump only follows commands on edges that stay in RUN, so any exit lands with it off.
    assign run_hold = (state_q == RUN) && (state_d == RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= GRANT_NONE;
            last_q      <= GRANT_DEP;
            ack_cnt_q   <= '0;
            pend_arr_q  <= 1'b0;
            pend_dep_q  <= 1'b0;
            pump_up_q   <= 1'b0;
            pump_down_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ack_cnt_q   <= ack_cnt_d;
            pend_arr_q  <= pend_arr_d;
            pend_dep_q  <= pend_dep_d;
            pump_up_q   <= run_hold && press;
            pump_down_q <= run_hold && depress;
            if (state_q == START) last_q <= sel_q;
        end
    end

`ifdef AIRLOCK_WATCHDOG_EN
    airlock_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .run_enter ((state_q == ACK) && busy),
        .run_active(state_q == RUN),
        .timeout   (wd_timeout)
    );
`else
    assign wd_timeout = 1'b0;
`endif

    assign bus.arr_start = (state_q == START) && (sel_q == GRANT_ARR);
    assign bus.dep_start = (state_q == START) && (sel_q == GRANT_DEP);
    assign bus.grant     = granting ? sel_q : GRANT_NONE;
    assign bus.pump_up   = pump_up_q;
    assign bus.pump_down = pump_down_q;
    assign bus.fault     = (state_q == FAULT);

endmodule

// File: tb/tb_airlock_arbiter.sv
// Self-checking bench for airlock_arbiter: directed scenarios, then randomized request
// episodes checked against a grant-order and pump-lag reference model.
module tb_airlock_arbiter;
    import airlock_pkg::*;

    localparam int ACK_WAIT  = 4;
    localparam int WD_CYCLES = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    airlock_if bus ();
    airlock_if bus_w ();

    airlock_arbiter #(
        .ACK_WAIT(ACK_WAIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    airlock_arbiter #(
        .ACK_WAIT       (ACK_WAIT),
        .WATCHDOG_CYCLES(WD_CYCLES)
    ) dut_wd (
        .clock(clock),
        .reset(reset),
        .bus  (bus_w)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit m_pend [2];
    int m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus.arr_req   = 1'b0;
        bus.dep_req   = 1'b0;
        bus_w.arr_req = 1'b0;
        bus_w.dep_req = 1'b0;
    endtask

    task automatic set_busy(input int side, input logic v);
        if (side == 0) bus.arr_busy = v;
        else           bus.dep_busy = v;
    endtask

    task automatic set_cmd(input int side, input logic up, input logic dn);
        if (side == 0) begin
            bus.arr_press = up; bus.arr_depress = dn;
        end else begin
            bus.dep_press = up; bus.dep_depress = dn;
        end
    endtask

    // Random commands from the side that does not hold the chamber.
    task automatic noise(input int side);
        set_cmd(1 - side, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic zero_inputs();
        bus.arr_req = 0; bus.dep_req = 0; bus.arr_busy = 0; bus.dep_busy = 0;
        bus.arr_press = 0; bus.arr_depress = 0; bus.dep_press = 0; bus.dep_depress = 0;
        bus_w.arr_req = 0; bus_w.dep_req = 0; bus_w.arr_busy = 0; bus_w.dep_busy = 0;
        bus_w.arr_press = 0; bus_w.arr_depress = 0; bus_w.dep_press = 0; bus_w.dep_depress = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clock);
        #1;
        check("rst_grant", bus.grant, GRANT_NONE);
        check("rst_fault", bus.fault, 0);
        check("rst_pump", {bus.pump_up, bus.pump_down}, 0);
        check("rst_start", {bus.arr_start, bus.dep_start}, 0);
        reset = 1'b0;
        m_pend[0] = 0;
        m_pend[1] = 0;
        m_last    = 1;
    endtask

    function automatic int model_pick();
        if (m_pend[0] && m_pend[1]) return (m_last == 0) ? 1 : 0;
        if (m_pend[0]) return 0;
        if (m_pend[1]) return 1;
        return -1;
    endfunction

    task automatic wait_start(input int side, input int lat, input string tag);
        int n = 0;
        while (bus.arr_start !== 1'b1 && bus.dep_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_side"}, {bus.dep_start, bus.arr_start}, (side == 0) ? 1 : 2);
        check({tag, "_grant"}, bus.grant, (side == 0) ? GRANT_ARR : GRANT_DEP);
        m_pend[side] = 0;
        m_last       = side;
    endtask

    // Called in the start-pulse cycle; returns in the IDLE cycle after the grant ends.
    task automatic serve(input int side, input int d, input int len, input int mid, input bit noack);
        logic [1:0] code;
        logic       up, dn;
        code = (side == 0) ? GRANT_ARR : GRANT_DEP;
        if (mid == 1) bus.arr_req = 1'b1;
        if (mid == 2) bus.dep_req = 1'b1;
        if (mid != 0 && mid - 1 != side) m_pend[mid - 1] = 1'b1;
        for (int i = 1; i <= (noack ? ACK_WAIT : d); i++) begin
            noise(side);
            tick();
            check("ack_grant", bus.grant, code);
            check("ack_nostart", bus.arr_start | bus.dep_start, 0);
        end
        if (noack) begin
            noise(side);
            tick();
            check("noack_drop", bus.grant, GRANT_NONE);
            return;
        end
        for (int j = 0; j < len; j++) begin
            set_busy(side, 1'b1);
            up = 0;
            dn = 0;
            if (j > 0) begin
                case ($urandom_range(0, 2))
                    1: up = 1;
                    2: dn = 1;
                    default: ;
                endcase
            end
            set_cmd(side, up, dn);
            noise(side);
            tick();
            check("run_grant", bus.grant, code);
            check("run_pump", {bus.pump_up, bus.pump_down}, {up, dn});
            check("run_nostart", bus.arr_start | bus.dep_start, 0);
        end
        set_busy(side, 1'b0);
        set_cmd(side, 0, 0);
        noise(side);
        tick();
        check("release_grant", bus.grant, GRANT_NONE);
        check("release_pump", {bus.pump_up, bus.pump_down}, 0);
        noise(side);
        tick();
        check("idle_grant", bus.grant, GRANT_NONE);
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit any;

        // reset values and a quiet idle cycle
        do_reset();
        tick();
        check("idle_after_rst", bus.grant, GRANT_NONE);

        // single arrival, 50-cycle run
        bus.arr_req = 1'b1;
        wait_start(0, 2, "single");
        serve(0, 2, 50, 0, 0);

        // tie after reset: arrival first, then departure
        do_reset();
        bus.arr_req = 1'b1;
        bus.dep_req = 1'b1;
        wait_start(0, 2, "tie_first");
        serve(0, 1, 6, 0, 0);
        wait_start(1, 1, "tie_second");
        serve(1, 3, 4, 0, 0);

        // alternation: after arrival alone, a tie goes to departure
        do_reset();
        bus.arr_req = 1'b1;
        wait_start(0, 2, "alt_solo");
        serve(0, 1, 3, 0, 0);
        bus.arr_req = 1'b1;
        bus.dep_req = 1'b1;
        wait_start(1, 2, "alt_first");
        serve(1, 2, 3, 0, 0);
        wait_start(0, 1, "alt_second");
        serve(0, 1, 3, 0, 0);

        // command isolation
        bus.arr_req = 1'b1;
        wait_start(0, 2, "iso");
        tick();
        set_busy(0, 1'b1);
        tick();
        set_cmd(0, 0, 1);
        set_cmd(1, 1, 0);
        tick();
        check("iso_down", bus.pump_down, 1);
        check("iso_up", bus.pump_up, 0);
        set_cmd(0, 0, 0);
        set_cmd(1, 0, 0);
        set_busy(0, 1'b0);
        tick();
        tick();

        // conflict -> sticky fault
        bus.arr_req = 1'b1;
        wait_start(0, 2, "conf");
        tick();
        set_busy(0, 1'b1);
        tick();
        set_cmd(0, 1, 1);
        tick();
        check("conf_fault", bus.fault, 1);
        check("conf_pump", {bus.pump_up, bus.pump_down}, 0);
        check("conf_grant", bus.grant, GRANT_NONE);
        set_cmd(0, 0, 0);
        set_busy(0, 1'b0);
        bus.dep_req = 1'b1;
        any = 0;
        repeat (8) begin
            tick();
            any |= bus.arr_start | bus.dep_start;
        end
        check("conf_nostart", any, 0);
        check("conf_sticky", bus.fault, 1);

        // asynchronous reset mid-run; pending departure is lost
        do_reset();
        bus.arr_req = 1'b1;
        wait_start(0, 2, "mid");
        tick();
        set_busy(0, 1'b1);
        tick();
        set_cmd(0, 1, 0);
        bus.dep_req = 1'b1;
        tick();
        check("mid_pump_on", bus.pump_up, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_pump", bus.pump_up, 0);
        check("mid_rst_grant", bus.grant, GRANT_NONE);
        @(posedge clock);
        #1;
        zero_inputs();
        reset = 1'b0;
        m_pend[0] = 0;
        m_pend[1] = 0;
        m_last    = 1;
        any = 0;
        repeat (6) begin
            tick();
            any |= bus.arr_start | bus.dep_start;
        end
        check("mid_lost", any, 0);

        // no acknowledge, then arrival still served
        bus.dep_req = 1'b1;
        wait_start(1, 2, "noack");
        serve(1, 0, 0, 0, 1);
        bus.arr_req = 1'b1;
        wait_start(0, 2, "after_noack");
        serve(0, 1, 4, 0, 0);

        // watchdog on the short-limit instance
        do_reset();
        bus_w.arr_req = 1'b1;
        n = 0;
        while (bus_w.arr_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("wd_start", n, 2);
        tick();
        bus_w.arr_busy = 1'b1;
        tick();
        for (int k = 1; k < WD_CYCLES; k++) tick();
        check("wd_before", bus_w.fault, 0);
        tick();
`ifdef AIRLOCK_WATCHDOG_EN
        check("wd_fault", bus_w.fault, 1);
        check("wd_grant", bus_w.grant, GRANT_NONE);
`else
        repeat (40) tick();
        check("wd_nofault", bus_w.fault, 0);
        check("wd_grant", bus_w.grant, GRANT_ARR);
`endif
        bus_w.arr_busy = 1'b0;

        // randomized request episodes
        do_reset();
        for (int ep = 0; ep < 25; ep++) begin
            int pat;
            int s;
            int iter;
            int mid;
            pat = int'($urandom_range(1, 3));
            bus.arr_req = pat[0];
            bus.dep_req = pat[1];
            if (pat[0]) m_pend[0] = 1;
            if (pat[1]) m_pend[1] = 1;
            iter = 0;
            s = model_pick();
            while (s >= 0 && iter < 8) begin
                wait_start(s, (iter == 0) ? 2 : 1, "rnd");
                mid = (iter < 6) ? int'($urandom_range(0, 2)) : 0;
                serve(s, int'($urandom_range(1, ACK_WAIT)), int'($urandom_range(2, 12)),
                      mid, ($urandom_range(0, 4) == 0));
                iter++;
                s = model_pick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
